// File: rtl/keypad_pkg.sv
// Shared encodings for the hex keypad scanner: FSM states, scan results,
// column drive patterns and the PmodKYPD key map.
package keypad_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPressDb,
        StHeld,
        StRelDb
    } kp_state_e;

    typedef enum logic [1:0] {
        ScanNone,
        ScanOne,
        ScanMulti
    } scan_res_e;

    localparam logic [3:0] ColDrive0 = 4'b1110;
    localparam logic [3:0] ColDrive1 = 4'b1101;
    localparam logic [3:0] ColDrive2 = 4'b1011;
    localparam logic [3:0] ColDrive3 = 4'b0111;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] drv;
        case (idx)
            2'd0:    drv = ColDrive0;
            2'd1:    drv = ColDrive1;
            2'd2:    drv = ColDrive2;
            default: drv = ColDrive3;
        endcase
        return drv;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            4'hF: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Combinational decode of one column's synchronized row lines into a
// pressed-key count (0, 1, 2 meaning two or more) and the hex code of the key.
module keypad_decoder
    import keypad_pkg::*;
(
    input  logic [3:0] i_row_s,
    input  logic [1:0] i_col_idx,
    output logic [1:0] o_count,
    output logic [3:0] o_code
);

    always_comb begin
        o_count = 2'd0;
        o_code  = 4'h0;
        for (int r = 0; r < 4; r++) begin
            if (!i_row_s[r]) begin
                if (o_count != 2'd2) begin
                    o_count = o_count + 2'd1;
                end
                o_code = key_map(r[1:0], i_col_idx);
            end
        end
    end

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with per-scan debouncing; accepted keys are shifted
// into a 16-bit entry register intended to drive the 4-digit display.
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_row,
    input  logic        i_clear,
    output logic [3:0]  o_col,
    output logic        o_key_valid,
    output logic [3:0]  o_key_code,
    output logic [15:0] o_value,
    output logic [2:0]  o_digit_count
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntTarget = CntW'(DEBOUNCE_SCANS);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    logic [3:0]      r_row_meta;
    logic [3:0]      r_row_s;
    logic [DivW-1:0] r_div;
    logic [1:0]      r_col_idx;
    logic [3:0]      r_col;
    logic [1:0]      r_acc_cnt;
    logic [3:0]      r_acc_code;

    kp_state_e       r_state;
    logic [CntW-1:0] r_cnt;
    logic [3:0]      r_cand;

    logic            r_key_valid;
    logic [3:0]      r_key_code;
    logic [15:0]     r_value;
    logic [2:0]      r_digit_count;

    logic            w_tick;
    logic            w_scan_done;
    logic [1:0]      w_col_count;
    logic [3:0]      w_col_code;
    logic [2:0]      w_sum;
    logic [1:0]      w_tot_cnt;
    logic [3:0]      w_tot_code;
    scan_res_e       w_res;

    kp_state_e       w_state_d;
    logic [CntW-1:0] w_cnt_d;
    logic [3:0]      w_cand_d;
    logic            w_accept;

    keypad_decoder u_decoder (
        .i_row_s   (r_row_s),
        .i_col_idx (r_col_idx),
        .o_count   (w_col_count),
        .o_code    (w_col_code)
    );

    assign w_tick      = (r_div == DivLast);
    assign w_scan_done = w_tick && (r_col_idx == 2'd3);

    // Merge this column into the running scan total, saturating at "two or more".
    assign w_sum      = 3'(r_acc_cnt) + 3'(w_col_count);
    assign w_tot_cnt  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_tot_code = (w_col_count == 2'd1) ? w_col_code : r_acc_code;

    always_comb begin
        unique case (w_tot_cnt)
            2'd0:    w_res = ScanNone;
            2'd1:    w_res = ScanOne;
            default: w_res = ScanMulti;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_row_meta <= 4'hF;
            r_row_s    <= 4'hF;
            r_div      <= '0;
            r_col_idx  <= 2'd0;
            r_col      <= ColDrive0;
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'h0;
        end else begin
            r_row_meta <= i_row;
            r_row_s    <= r_row_meta;
            if (w_tick) begin
                r_div     <= '0;
                r_col_idx <= r_col_idx + 2'd1;
                r_col     <= col_drive(r_col_idx + 2'd1);
                if (r_col_idx == 2'd3) begin
                    r_acc_cnt  <= 2'd0;
                    r_acc_code <= 4'h0;
                end else begin
                    r_acc_cnt  <= w_tot_cnt;
                    r_acc_code <= w_tot_code;
                end
            end else begin
                r_div <= r_div + DivW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_cand  <= 4'h0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_cand  <= w_cand_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_cand_d  = r_cand;
        w_accept  = 1'b0;
        if (w_scan_done) begin
            unique case (r_state)
                StIdle: begin
                    if (w_res == ScanOne) begin
                        w_cand_d = w_tot_code;
                        w_cnt_d  = CntOne;
                        if (w_cnt_d == CntTarget) begin
                            w_state_d = StHeld;
                            w_accept  = 1'b1;
                        end else begin
                            w_state_d = StPressDb;
                        end
                    end
                end
                StPressDb: begin
                    if (w_res == ScanOne && w_tot_code == r_cand) begin
                        w_cnt_d = r_cnt + CntOne;
                        if (w_cnt_d == CntTarget) begin
                            w_state_d = StHeld;
                            w_accept  = 1'b1;
                        end
                    end else begin
                        w_state_d = StIdle;
                        w_cnt_d   = '0;
                    end
                end
                StHeld: begin
                    if (w_res == ScanNone) begin
                        w_cnt_d   = CntOne;
                        w_state_d = (w_cnt_d == CntTarget) ? StIdle : StRelDb;
                    end
                end
                StRelDb: begin
                    if (w_res == ScanNone) begin
                        w_cnt_d = r_cnt + CntOne;
                        if (w_cnt_d == CntTarget) begin
                            w_state_d = StIdle;
                        end
                    end else begin
                        // A bounce during release is the same key still down: no new accept.
                        w_state_d = StHeld;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_key_valid   <= 1'b0;
            r_key_code    <= 4'h0;
            r_value       <= 16'h0000;
            r_digit_count <= 3'd0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= w_cand_d;
            end
            if (i_clear) begin
                r_value       <= 16'h0000;
                r_digit_count <= 3'd0;
            end else if (w_accept) begin
                r_value <= {r_value[11:0], w_cand_d};
                if (r_digit_count != 3'd4) begin
                    r_digit_count <= r_digit_count + 3'd1;
                end
            end
        end
    end

    assign o_col         = r_col;
    assign o_key_valid   = r_key_valid;
    assign o_key_code    = r_key_code;
    assign o_value       = r_value;
    assign o_digit_count = r_digit_count;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a behavioural keypad matrix model
// (SCAN_DIV=4, DEBOUNCE_SCANS=2, so one scan is 16 cycles).
module tb_hex_keypad_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] value;
    logic [2:0]  digit_count;

    logic [15:0] keys;
    int          n_vec = 0;
    int          n_miss = 0;
    int          pulses = 0;
    int          p0;

    always #5 clk = ~clk;

    hex_keypad_entry #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_row         (row),
        .i_clear       (clear),
        .o_col         (col),
        .o_key_valid   (key_valid),
        .o_key_code    (key_code),
        .o_value       (value),
        .o_digit_count (digit_count)
    );

    // Pressed key at (r, c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (key_valid === 1'b1) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] key_bit(input int r, input int c);
        logic [15:0] b;
        b = '0;
        b[r*4+c] = 1'b1;
        return b;
    endfunction

    task automatic scans(input int n);
        repeat (n * 16) @(negedge clk);
    endtask

    task automatic enter(input int r, input int c, input logic [3:0] code,
                         input logic [15:0] exp_val, input logic [2:0] exp_cnt);
        keys = key_bit(r, c);
        scans(3);
        keys = '0;
        scans(3);
        check("entry key_code", 32'(key_code), 32'(code));
        check("entry value", 32'(value), 32'(exp_val));
        check("entry digit_count", 32'(digit_count), 32'(exp_cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        keys  = '0;

        // Reset and column rotation
        repeat (3) @(negedge clk);
        check("reset col", 32'(col), 32'h0000000E);
        check("reset value", 32'(value), 32'h0);
        check("reset digit_count", 32'(digit_count), 32'h0);
        check("reset key_valid", 32'(key_valid), 32'h0);
        check("reset key_code", 32'(key_code), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("col dwell", 32'(col), 32'h0000000E);
        @(negedge clk);
        check("col1", 32'(col), 32'h0000000D);
        repeat (4) @(negedge clk);
        check("col2", 32'(col), 32'h0000000B);
        repeat (4) @(negedge clk);
        check("col3", 32'(col), 32'h00000007);
        repeat (4) @(negedge clk);
        check("col wrap", 32'(col), 32'h0000000E);

        // Single press '5' from a scan boundary, held 5 scans
        p0 = pulses;
        keys = key_bit(1, 1);
        repeat (31) @(negedge clk);
        check("press early", 32'(key_valid), 32'h0);
        @(negedge clk);
        check("press latency", 32'(key_valid), 32'h1);
        check("press code", 32'(key_code), 32'h5);
        @(negedge clk);
        check("press one-shot", 32'(key_valid), 32'h0);
        repeat (47) @(negedge clk);
        keys = '0;
        scans(4);
        check("press pulses", 32'(pulses - p0), 32'h1);
        check("press value", 32'(value), 32'h0005);
        check("press digit_count", 32'(digit_count), 32'h1);

        // Entry sequence 1 2 3 A B
        p0 = pulses;
        enter(0, 0, 4'h1, 16'h0051, 3'd2);
        enter(0, 1, 4'h2, 16'h0512, 3'd3);
        enter(0, 2, 4'h3, 16'h5123, 3'd4);
        enter(0, 3, 4'hA, 16'h123A, 3'd4);
        enter(1, 3, 4'hB, 16'h23AB, 3'd4);
        check("seq pulses", 32'(pulses - p0), 32'h5);

        // Bounce: '8' for one scan only
        p0 = pulses;
        keys = key_bit(2, 1);
        scans(1);
        keys = '0;
        scans(3);
        check("bounce pulses", 32'(pulses - p0), 32'h0);
        // Ghosting: '1' and '2' together
        keys = key_bit(0, 0) | key_bit(0, 1);
        scans(4);
        keys = '0;
        scans(3);
        check("multi pulses", 32'(pulses - p0), 32'h0);
        check("multi value", 32'(value), 32'h23AB);
        check("multi key_code", 32'(key_code), 32'hB);

        // Plain clear, then build 0x1234
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear value", 32'(value), 32'h0);
        check("clear digit_count", 32'(digit_count), 32'h0);
        repeat (15) @(negedge clk);
        enter(0, 0, 4'h1, 16'h0001, 3'd1);
        enter(0, 1, 4'h2, 16'h0012, 3'd2);
        enter(0, 2, 4'h3, 16'h0123, 3'd3);
        enter(1, 0, 4'h4, 16'h1234, 3'd4);

        // Clear colliding with the accept of '7'
        keys = key_bit(2, 0);
        repeat (31) @(negedge clk);
        check("collide pre value", 32'(value), 32'h1234);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("collide key_valid", 32'(key_valid), 32'h1);
        check("collide key_code", 32'(key_code), 32'h7);
        check("collide value", 32'(value), 32'h0);
        check("collide digit_count", 32'(digit_count), 32'h0);
        repeat (16) @(negedge clk);
        keys = '0;
        scans(3);

        // Reset during PRESS_DB of '9'
        p0 = pulses;
        keys = key_bit(2, 2);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst key_code", 32'(key_code), 32'h0);
        check("midrst col", 32'(col), 32'h0000000E);
        repeat (31) @(negedge clk);
        check("midrst early", 32'(key_valid), 32'h0);
        check("midrst no pulse", 32'(pulses - p0), 32'h0);
        @(negedge clk);
        check("midrst key_valid", 32'(key_valid), 32'h1);
        check("midrst key_code", 32'(key_code), 32'h9);
        check("midrst value", 32'(value), 32'h0009);
        check("midrst digit_count", 32'(digit_count), 32'h1);
        keys = '0;
        scans(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
